// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and constants for the memory access unit:
//               FSM state encoding, requester port id and default depth.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Access FSM: arbitrate in IDLE, drive memory in ACCESS, hold response in RESP
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Which requester owns the in-flight access
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    // Default number of addressable memory words
    localparam int unsigned c_MEM_DEPTH_DEFAULT = 513;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_access_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_arb
// Description : Fixed-priority two-requester arbiter. Request/grant bit 1 is
//               the data port and always wins over bit 0 (instruction fetch).
//               Grants are one-hot and only issued while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_arb (
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // Data port has absolute priority; fetch only when data is not asking
    always_comb begin
        o_gnt    = 2'b00;
        o_gnt[1] = i_en & i_req[1];
        o_gnt[0] = i_en & i_req[0] & ~i_req[1];
    end

endmodule : mem_access_arb
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Shares one single-port memory between an instruction-fetch
//               port and a data port. Each access takes a grant cycle, one
//               ACCESS cycle driving the memory, and a RESP phase held until
//               the owning requester accepts the response.
//               Optional feature macro: MEM_BOUNDS_CHECK_EN - accesses at or
//               beyond MEM_DEPTH are blocked and answered with rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = c_MEM_DEPTH_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    // instruction-fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        if_rready,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        d_rready,
    // shared response error
    output logic        rsp_err,
    // memory side
    output logic [31:0] Address,
    output logic [31:0] writeData,
    output logic        writeEnable,
    input  logic [31:0] MemData
);

    state_t      r_state;
    port_id_t    r_port;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_if_rvalid;
    logic        r_d_rvalid;

    logic        w_arb_en;
    logic [1:0]  w_gnt;
    logic        w_oob;
    logic        w_rsp_done;

    // A grant taken during reset would be discarded, so do not advertise one
    assign w_arb_en = (r_state == IDLE) && !Reset;

    mem_access_arb u_arb (
        .i_en  (w_arb_en),
        .i_req ({d_req, if_req}),
        .o_gnt (w_gnt)
    );

    assign d_gnt  = w_gnt[1];
    assign if_gnt = w_gnt[0];

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [31:0] c_MEM_DEPTH_W = 32'(MEM_DEPTH);
    // Captured address outside the attached memory
    assign w_oob = (r_addr >= c_MEM_DEPTH_W);
`else
    assign w_oob = 1'b0;
`endif

    // Response accepted by the port that owns it; other port's rready is ignored
    assign w_rsp_done = (r_port == PORT_IF) ? (r_if_rvalid & if_rready)
                                            : (r_d_rvalid  & d_rready);

    // Memory strobe only in ACCESS, never under reset or for blocked addresses
    assign writeEnable = (r_state == ACCESS) && r_we && !w_oob && !Reset;
    assign Address     = r_addr;
    assign writeData   = r_wdata;

    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = (r_port == PORT_IF) ? r_rdata : 32'h0;
    assign d_rdata   = (r_port == PORT_D)  ? r_rdata : 32'h0;
    assign rsp_err   = r_err;

    // Access FSM with request capture and registered response outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_port      <= PORT_IF;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_err       <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt[1]) begin
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                        r_we    <= d_we;
                        r_port  <= PORT_D;
                        r_state <= ACCESS;
                    end else if (w_gnt[0]) begin
                        r_addr  <= if_addr;
                        r_wdata <= 32'h0;
                        r_we    <= 1'b0;
                        r_port  <= PORT_IF;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rdata     <= (r_we || w_oob) ? 32'h0 : MemData;
                    r_err       <= w_oob;
                    r_if_rvalid <= (r_port == PORT_IF);
                    r_d_rvalid  <= (r_port == PORT_D);
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_if_rvalid <= 1'b0;
                        r_d_rvalid  <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_access_unit
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_DEPTH, default 513: number of addressable words in the attached memory (indices 0..MEM_DEPTH-1).
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request; held high until if_gnt.
REQ-005 if_addr  input  32  fetch address, used directly as the memory index.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid / if_rdata  output  1 / 32  fetch response valid / read data.
REQ-008 if_rready  input  1  fetch requester accepts the response.
REQ-009 d_req, d_we  input  1 each  data request; d_we=1 write, d_we=0 read.
REQ-010 d_addr, d_wdata  input  32 each  data address / write data.
REQ-011 d_gnt, d_rvalid  output  1 each  data accept / data response valid.
REQ-012 d_rdata  output  32  data read data; 0 for writes.
REQ-013 d_rready  input  1  data requester accepts the response.
REQ-014 rsp_err  output  1  error flag, qualified by either rvalid.
REQ-015 Address, writeData  output  32 each  memory-side address / write data.
REQ-016 writeEnable  output  1  memory-side write strobe.
REQ-017 MemData  input  32  memory-side combinational read data.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-019 In IDLE with d_req=1, d_gnt SHALL be 1 combinationally and if_gnt 0 (fixed data priority).
- Else, with if_req=1, if_gnt SHALL be 1.
- Gnt is never asserted outside IDLE.
REQ-020 On a grant edge, the unit SHALL capture addr, wdata, we and the port id, and SHALL go to ACCESS.
- Fetch grants capture we=0.
REQ-021 ACCESS SHALL last exactly one cycle.
- Address = captured addr; writeData = captured wdata; writeEnable = captured we.
- The edge captures MemData into the response register (0 for writes) and moves the FSM to RESP.
REQ-022 Outside ACCESS, writeEnable SHALL be 0, and Address/writeData SHALL hold the last captured values.
REQ-023 In RESP, only the granted port's rvalid SHALL be 1, and rdata SHALL be stable.
- The FSM stays in RESP until that port's rready=1, then returns to IDLE on that edge.
REQ-024 Latency SHALL be: rvalid asserted 2 cycles after the grant edge; minimum 3 cycles per access.
REQ-025 A requester not granted SHALL receive no gnt and no rvalid; its request stays pending.
REQ-026 An rready seen while rvalid=0 SHALL be ignored.

Reset
REQ-027 Reset SHALL force, on the next edge:
- state IDLE;
- Address, writeData, response register and captured registers 0;
- rvalid, gnt and rsp_err 0.
REQ-028 writeEnable SHALL be gated with !Reset, so a reset asserted during ACCESS produces no memory write.
REQ-029 An in-flight access interrupted by reset SHALL be dropped with no response.

Configuration
REQ-030 With MEM_BOUNDS_CHECK_EN defined, a granted access with addr >= MEM_DEPTH SHALL:
- keep writeEnable 0 in ACCESS;
- return rdata 0 with rsp_err=1 in RESP.
REQ-031 Without MEM_BOUNDS_CHECK_EN, rsp_err SHALL be tied 0, and all addresses SHALL pass to Address unchanged.

Structure
REQ-032 Package mem_access_pkg SHALL hold:
- the FSM state enum (IDLE/ACCESS/RESP);
- the port-id type (PORT_IF, PORT_D);
- the default MEM_DEPTH constant.
REQ-033 The fixed-priority grant logic SHALL be a sub-module mem_access_arb (2 requests in, 2 one-hot grants out, enable = state IDLE).

Verification
REQ-034 Fetch read: memory[128]=32'h8c030000, if_req with if_addr=128 -> if_gnt in cycle 0; if_rvalid=1 in cycle 2 with if_rdata=32'h8c030000.
REQ-035 Write then read: d_we=1, d_addr=6, d_wdata=32'h0000000D -> writeEnable=1 for exactly one cycle at Address=6; a following read of addr 6 returns 32'h0000000D.
REQ-036 Simultaneous: if_req and d_req asserted together -> d_gnt first.
- if_gnt follows in the IDLE cycle after the d_rready handshake.
- The fetch request is never lost.
REQ-037 Backpressure: d_rready held low 5 cycles -> d_rvalid and d_rdata stable; no gnt issued until the handshake.
REQ-038 Reset in ACCESS of a write to addr 6 -> memory[6] unchanged; all outputs 0 after the reset edge.
REQ-039 With MEM_BOUNDS_CHECK_EN, read addr 600 -> rsp_err=1, rdata 0; a write to addr 600 gives writeEnable 0 throughout.
